// File: rtl/controle_navegacao.sv
// Wall-following navigation controller for a cleaning robot: evaluates sensors,
// then runs one atomic action (advance, left/right turn, brush) or latches stuck.
module controle_navegacao #(
   parameter int T_REMOVE  = 4,
   parameter int MAX_GIROS = 4
) (
   input  logic       clockc3,
   input  logic       reset,
   input  logic       enable,
   input  logic       head,
   input  logic       left,
   input  logic       under,
   output logic       girar,
   output logic       avancar,
   output logic       remover,
   output logic       preso,
   output logic [2:0] estado,
   output logic [7:0] passos
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      AVALIA   = 3'b001,
      AVANCA   = 3'b010,
      GIRA_ESQ = 3'b011,
      GIRA_DIR = 3'b100,
      REMOVE   = 3'b101,
      PRESO    = 3'b110
   } state_t;

   localparam logic [2:0] GirosMax  = 3'(MAX_GIROS);
   localparam logic [3:0] RemoveEnd = 4'(T_REMOVE - 1);

   state_t     state_q, state_d;
   logic [7:0] passos_q, passos_d;
   logic [2:0] giros_q, giros_d;
   logic       ignoraEsq_q, ignoraEsq_d;
   logic [1:0] giroCnt_q, giroCnt_d;
   logic [3:0] remCnt_q, remCnt_d;
   logic [2:0] girosInc;

   always_ff @(posedge clockc3 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         passos_q    <= 8'd0;
         giros_q     <= 3'd0;
         ignoraEsq_q <= 1'b0;
         giroCnt_q   <= 2'd0;
         remCnt_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         passos_q    <= passos_d;
         giros_q     <= giros_d;
         ignoraEsq_q <= ignoraEsq_d;
         giroCnt_q   <= giroCnt_d;
         remCnt_q    <= remCnt_d;
      end
   end

   // Turns count toward the stuck limit; the counter saturates so it never wraps past it.
   assign girosInc = (giros_q == GirosMax) ? giros_q : giros_q + 3'd1;

   always_comb begin
      state_d     = state_q;
      passos_d    = passos_q;
      giros_d     = giros_q;
      ignoraEsq_d = ignoraEsq_q;
      giroCnt_d   = giroCnt_q;
      remCnt_d    = remCnt_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = AVALIA;
         end
         AVALIA: begin
            if (!enable)                   state_d = IDLE;
            else if (under)                state_d = REMOVE;
            else if (!left && !ignoraEsq_q) state_d = GIRA_ESQ;
            else if (!head)                state_d = AVANCA;
            else                           state_d = GIRA_DIR;
         end
         AVANCA: begin
            passos_d    = passos_q + 8'd1;
            giros_d     = 3'd0;
            ignoraEsq_d = 1'b0;
            state_d     = AVALIA;
         end
         GIRA_ESQ: begin
            ignoraEsq_d = 1'b1;
            giros_d     = girosInc;
            state_d     = (girosInc == GirosMax) ? PRESO : AVALIA;
         end
         GIRA_DIR: begin
            if (giroCnt_q == 2'd2) begin
               giroCnt_d   = 2'd0;
               giros_d     = girosInc;
               ignoraEsq_d = 1'b0;
               state_d     = (girosInc == GirosMax) ? PRESO : AVALIA;
            end else begin
               giroCnt_d = giroCnt_q + 2'd1;
            end
         end
         REMOVE: begin
            if (remCnt_q == RemoveEnd) begin
               remCnt_d = 4'd0;
               state_d  = AVALIA;
            end else begin
               remCnt_d = remCnt_q + 4'd1;
            end
         end
         PRESO: begin
            if (!enable) begin
               state_d     = IDLE;
               giros_d     = 3'd0;
               ignoraEsq_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Action outputs come straight from the state register so sensors never glitch them.
   assign girar   = (state_q == GIRA_ESQ) || (state_q == GIRA_DIR);
   assign avancar = (state_q == AVANCA);
   assign remover = (state_q == REMOVE);
   assign preso   = (state_q == PRESO);
   assign estado  = state_q;
   assign passos  = passos_q;

endmodule

// File: doc/controle_navegacao.md
CONTROLE_NAVEGACAO -- requirements
Module: controle_navegacao

Interface
REQ-001 Parameter T_REMOVE, default 4: number of cycles remover is held per cleaning action (range 1..15).
REQ-002 Parameter MAX_GIROS, default 4: consecutive 90-degree turns without an advance that declare the robot stuck (range 1..7).
REQ-003 clockc3  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run request; 0 parks the controller in IDLE.
REQ-006 head  input  1  1 = obstacle directly ahead.
REQ-007 left  input  1  1 = wall present on the left side.
REQ-008 under  input  1  1 = debris under the robot.
REQ-009 girar  output  1  one 90-degree left rotation per cycle high; drives the downstream orientation stage.
REQ-010 avancar  output  1  one-cycle pulse, move one cell forward.
REQ-011 remover  output  1  cleaner brush active.
REQ-012 preso  output  1  stuck flag.
REQ-013 estado  output  3  current state code.
REQ-014 passos  output  8  count of advances since reset.

Function
REQ-015 State codes SHALL be IDLE=000, AVALIA=001, AVANCA=010, GIRA_ESQ=011, GIRA_DIR=100, REMOVE=101, PRESO=110; 111 unused, recovers to IDLE on the next edge.
REQ-016 girar, avancar, remover, preso SHALL be decoded from registered state only, with no combinational path from any input.
REQ-017 IDLE: all action outputs 0; enable=1 -> AVALIA on the next edge.
REQ-018 AVALIA, evaluated in priority order: enable=0 -> IDLE; under=1 -> REMOVE; left=0 and ignora_esq=0 -> GIRA_ESQ; head=0 -> AVANCA; otherwise GIRA_DIR.
REQ-019 AVANCA: avancar=1 for exactly 1 cycle; passos+1 (mod 256, 255 wraps to 0); giros and ignora_esq cleared; -> AVALIA.
REQ-020 GIRA_ESQ: girar=1 for exactly 1 cycle; ignora_esq set; giros+1; -> AVALIA.
REQ-021 GIRA_DIR: girar=1 for exactly 3 consecutive cycles (right turn = 3 left rotations), tracked by a 2-bit sub-counter 0..2; giros+1 once on the last cycle; ignora_esq cleared; -> AVALIA.
REQ-022 REMOVE: remover=1 for exactly T_REMOVE cycles; giros unchanged; -> AVALIA; if under is still 1 there, REMOVE repeats.
REQ-023 Stuck rule: giros is a 3-bit counter saturating at MAX_GIROS; when it reaches MAX_GIROS, the transition out of the turn state SHALL go to PRESO instead of AVALIA.
REQ-024 PRESO: preso=1, all other action outputs 0; exit only to IDLE on enable=0, which clears giros and ignora_esq; otherwise hold.
REQ-025 Actions are atomic: enable, head, left, under changes during AVANCA, GIRA_ESQ, GIRA_DIR or REMOVE SHALL NOT shorten or abort them; they are sampled only in AVALIA, IDLE, PRESO.
REQ-026 Exactly one of girar, avancar, remover, preso SHALL be high in any cycle, or none.
REQ-027 From enable rising in IDLE, the first action output SHALL appear 2 cycles later (IDLE -> AVALIA -> action).

Reset
REQ-028 reset=1 SHALL force immediately, without a clock: state IDLE, estado=000, girar=avancar=remover=preso=0, passos=0, giros=0, ignora_esq=0, GIRA_DIR and REMOVE sub-counters=0.
REQ-029 reset asserted mid-action (e.g. 2nd cycle of GIRA_DIR) SHALL drop girar at once; no remaining rotation pulses follow release.
REQ-030 After reset release, the controller SHALL stay in IDLE until enable=1 is sampled on a clockc3 edge.

Verification
REQ-031 enable=1, left=1, head=0, under=0 -> alternating AVALIA/AVANCA, avancar pulses every 2nd cycle, passos increments 1,2,3...
REQ-032 left=0, head=0 -> GIRA_ESQ (girar 1 cycle), then AVANCA (ignora_esq blocks a second left turn), then GIRA_ESQ again.
REQ-033 left=1, head=1 held -> GIRA_DIR girar high 3 cycles, repeated; after the 4th turn preso=1, estado=110; enable=0 -> IDLE, preso=0.
REQ-034 under=1 for one AVALIA -> remover high exactly 4 cycles with T_REMOVE=4; then under=0 -> normal evaluation.
REQ-035 256 advances -> passos wraps 255 -> 0; reset during cycle 2 of GIRA_DIR -> girar=0 same cycle, estado=000, passos=0.
